// File: rtl/coef_pkg_flex.sv
// rtl/coef_pkg_flex.sv - shared state encoding and parameter defaults for the coefficient read sequencer
//
// Purpose : common definitions imported by coef_read_seq_flex and its valid pipe.
// Contents: state_t encoding (IDLE/READ/DRAIN/UPDATE), default NUM_TAPS, ADDR_W, RD_LAT.
package coef_pkg_flex;

    localparam int NUM_TAPS_DEF = 10;
    localparam int ADDR_W_DEF   = 4;
    localparam int RD_LAT_DEF   = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        DRAIN  = 2'd2,
        UPDATE = 2'd3
    } state_t;

endpackage

// File: rtl/tap_valid_pipe_flex.sv
// rtl/tap_valid_pipe_flex.sv - DEPTH-stage shift register carrying {valid, idx, last}
//
// Purpose : delays the read-issue tag by the SRAM read latency so that valid/idx/last
//           line up with the data returned for that address.
// Ports   : iClk12M, iRst (async, active-high)
//           iValid, iIdx, iLast  - tag launched with the address
//           oValid, oIdx, oLast  - same tag DEPTH cycles later (registered)
module tap_valid_pipe_flex
    import coef_pkg_flex::*;
#(
    parameter int DEPTH = RD_LAT_DEF,
    parameter int IDX_W = ADDR_W_DEF
) (
    input  logic             iClk12M,
    input  logic             iRst,
    input  logic             iValid,
    input  logic [IDX_W-1:0] iIdx,
    input  logic             iLast,
    output logic             oValid,
    output logic [IDX_W-1:0] oIdx,
    output logic             oLast
);

    localparam int W = IDX_W + 2;

    logic [W-1:0] r_stage [DEPTH];

    always_ff @(posedge iClk12M or posedge iRst) begin
        if (iRst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= {iValid, iIdx, iLast};
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign {oValid, oIdx, oLast} = r_stage[DEPTH-1];

endmodule

// File: rtl/coef_read_seq_flex.sv
// rtl/coef_read_seq_flex.sv - FSM owning the coefficient SP-SRAM mux and sequential tap reads
//
// Purpose : outside update mode, reads NUM_TAPS coefficients (one per cycle) on every
//           accepted sample strobe and tags the returned data with valid/index/done.
//           In update mode hands the SRAM to the Top via oUpdateFlag. The mux select
//           only changes from IDLE, so it never flips inside a read sequence.
// Ports   : iClk12M, iRst (async, active-high)
//           iUpdateReq  - level, Top requests coefficient update mode
//           iSampleEn   - 1-cycle strobe, start a read sequence
//           oUpdateFlag - mux select (1 = Top owns SRAM)
//           oCsn_Fsm, oWrn_Fsm, oAddr_Fsm - SRAM control/address (active-low strobes)
//           oTapValid, oTapIdx, oDone     - read data tag aligned to SRAM data
//           oBusy       - sequence in progress (READ or DRAIN)
//           oDropped    - 1-cycle pulse, a strobe was rejected
module coef_read_seq_flex
    import coef_pkg_flex::*;
#(
    parameter int NUM_TAPS = NUM_TAPS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int RD_LAT   = RD_LAT_DEF
) (
    input  logic              iClk12M,
    input  logic              iRst,
    input  logic              iUpdateReq,
    input  logic              iSampleEn,
    output logic              oUpdateFlag,
    output logic              oCsn_Fsm,
    output logic              oWrn_Fsm,
    output logic [ADDR_W-1:0] oAddr_Fsm,
    output logic              oTapValid,
    output logic [ADDR_W-1:0] oTapIdx,
    output logic              oDone,
    output logic              oBusy,
    output logic              oDropped
);

    localparam logic [ADDR_W-1:0] LP_LAST_TAP = ADDR_W'(NUM_TAPS - 1);
    localparam logic [1:0]        LP_LAST_DRN = 2'(RD_LAT - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [1:0]        r_drain;
    logic              r_upd_flag;
    logic              r_csn;
    logic              r_busy;
    logic              r_dropped;

    state_t            w_state_nxt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic [1:0]        w_drain_nxt;
    logic              w_drop;

    logic              w_rd_valid;
    logic [ADDR_W-1:0] w_rd_idx;
    logic              w_rd_last;
    logic              w_pipe_last;

    always_ff @(posedge iClk12M or posedge iRst) begin
        if (iRst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_drain <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_drain <= w_drain_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_drain_nxt = r_drain;
        // Only IDLE without a pending update request can take a strobe.
        w_drop      = iSampleEn && !((r_state == IDLE) && !iUpdateReq);
        case (r_state)
            IDLE: begin
                if (iUpdateReq) begin
                    w_state_nxt = UPDATE;
                    w_cnt_nxt   = '0;
                end else if (iSampleEn) begin
                    w_state_nxt = READ;
                    w_cnt_nxt   = '0;
                end
            end
            READ: begin
                if (r_cnt == LP_LAST_TAP) begin
                    // Address stays on the bus at its last value while draining.
                    w_state_nxt = DRAIN;
                    w_drain_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            DRAIN: begin
                if (r_drain == LP_LAST_DRN) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_drain_nxt = r_drain + 1'b1;
                end
            end
            UPDATE: begin
                w_cnt_nxt = '0;
                if (!iUpdateReq) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so they change in
    // the same cycle the state register does and carry no combinational glitches.
    always_ff @(posedge iClk12M or posedge iRst) begin
        if (iRst) begin
            r_upd_flag <= 1'b0;
            r_csn      <= 1'b1;
            r_busy     <= 1'b0;
            r_dropped  <= 1'b0;
        end else begin
            r_upd_flag <= (w_state_nxt == UPDATE);
            r_csn      <= (w_state_nxt != READ);
            r_busy     <= (w_state_nxt == READ) || (w_state_nxt == DRAIN);
            r_dropped  <= w_drop;
        end
    end

    // Tag launched in the cycle the address is on the bus; idx/last are gated by
    // valid so the pipe output is clean outside read sequences.
    assign w_rd_valid = !r_csn;
    assign w_rd_idx   = w_rd_valid ? r_cnt : '0;
    assign w_rd_last  = w_rd_valid && (r_cnt == LP_LAST_TAP);

    tap_valid_pipe_flex #(
        .DEPTH (RD_LAT),
        .IDX_W (ADDR_W)
    ) u_pipe (
        .iClk12M (iClk12M),
        .iRst    (iRst),
        .iValid  (w_rd_valid),
        .iIdx    (w_rd_idx),
        .iLast   (w_rd_last),
        .oValid  (oTapValid),
        .oIdx    (oTapIdx),
        .oLast   (w_pipe_last)
    );

    assign oUpdateFlag = r_upd_flag;
    assign oCsn_Fsm    = r_csn;
    assign oWrn_Fsm    = 1'b1;
    assign oAddr_Fsm   = r_cnt;
    assign oDone       = w_pipe_last;
    assign oBusy       = r_busy;
    assign oDropped    = r_dropped;

endmodule
